// File: rtl/mem_seq_pkg.sv
// ---------------------------------------------------------------------------
// mem_seq_pkg
// Shared types and width helpers for the burst sequencer that sits in front of
// the BRAM-backed memory array.
//   seq_state_t  : sequencer FSM state encoding (IDLE / WRITE / READ)
//   addr_width() : word-address width for a given array depth
//   idx_width()  : burst-index width (offset / beat counter) for a burst length
// ---------------------------------------------------------------------------
package mem_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } seq_state_t;

   // Never returns 0 so that a degenerate size still yields a legal vector.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int idx_width(input int bl);
      return (bl > 1) ? $clog2(bl) : 1;
   endfunction

endpackage

// File: rtl/burst_sequencer_if.sv
// ---------------------------------------------------------------------------
// burst_sequencer_if
// Bundles the command, write-beat, read-beat and array-side signals of the
// burst sequencer.
//   modport slave  : the sequencer (accepts commands, drives the array)
//   modport master : the surrounding logic (issues commands, models the array)
// Optional: cmd_bc exists only when BURST_CHOP_EN is defined.
// ---------------------------------------------------------------------------
interface burst_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2048
);
   import mem_seq_pkg::*;

   localparam int AW = addr_width(DEPTH);

   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_wr;
   logic [AW-1:0]    cmd_addr;
`ifdef BURST_CHOP_EN
   logic             cmd_bc;
`endif
   logic [WIDTH-1:0] wr_data;
   logic             wr_valid;
   logic             wr_ready;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             rd_last;
   logic [AW-1:0]    arr_addr;
   logic             arr_rd_o_wr;
   logic [WIDTH-1:0] arr_i_data;
   logic [WIDTH-1:0] arr_o_data;

   modport slave (
      input  cmd_valid, cmd_wr, cmd_addr,
`ifdef BURST_CHOP_EN
      input  cmd_bc,
`endif
      input  wr_data, wr_valid, arr_o_data,
      output cmd_ready, wr_ready, rd_data, rd_valid, rd_last,
      output arr_addr, arr_rd_o_wr, arr_i_data
   );

   modport master (
      output cmd_valid, cmd_wr, cmd_addr,
`ifdef BURST_CHOP_EN
      output cmd_bc,
`endif
      output wr_data, wr_valid, arr_o_data,
      input  cmd_ready, wr_ready, rd_data, rd_valid, rd_last,
      input  arr_addr, arr_rd_o_wr, arr_i_data
   );

endinterface

// File: rtl/burst_addr_gen.sv
// ---------------------------------------------------------------------------
// burst_addr_gen
// Holds the burst base/offset registers and produces the array word address
// with sequential wrap inside the aligned burst group (critical word first).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_load       : capture i_addr as the start of a new burst (wins over advance)
//   i_advance    : step the offset by one beat
//   i_chop       : current burst is half length (wrap in the BL/2 group)
//   i_addr       : start word address
//   o_addr       : base | offset, straight from the registers
// ---------------------------------------------------------------------------
module burst_addr_gen
   import mem_seq_pkg::*;
#(
   parameter  int DEPTH = 2048,
   parameter  int BL    = 8,
   localparam int AW    = addr_width(DEPTH),
   localparam int OW    = idx_width(BL)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_load,
   input  logic          i_advance,
   input  logic          i_chop,
   input  logic [AW-1:0] i_addr,
   output logic [AW-1:0] o_addr
);

   localparam logic [AW-1:0] BASE_MASK = ~(AW'(BL - 1));
   localparam logic [OW-1:0] FULL_WRAP = '1;

   logic [AW-1:0] r_base;
   logic [OW-1:0] r_offset;
   logic [OW-1:0] w_inc;
   logic [OW-1:0] w_wrap_mask;
   logic [OW-1:0] w_offset_next;

   // For a chopped burst the top offset bit stays frozen, so it behaves as
   // part of the base and the low bits wrap inside the BL/2 group.
   assign w_wrap_mask   = i_chop ? (FULL_WRAP >> 1) : FULL_WRAP;
   assign w_inc         = r_offset + OW'(1);
   assign w_offset_next = (r_offset & ~w_wrap_mask) | (w_inc & w_wrap_mask);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_base   <= '0;
         r_offset <= '0;
      end else if (i_load) begin
         r_base   <= i_addr & BASE_MASK;
         r_offset <= i_addr[OW-1:0];
      end else if (i_advance) begin
         r_offset <= w_offset_next;
      end
   end

   // Base has its low OW bits cleared, so OR is a carry-free concatenation.
   assign o_addr = r_base | AW'(r_offset);

endmodule

// File: rtl/burst_sequencer.sv
// ---------------------------------------------------------------------------
// burst_sequencer
// Accepts one column command at a time and expands it into BL single-word
// accesses to a BRAM array (registered read, 1-cycle latency). Reads stream
// back with rd_valid/rd_last; writes consume one beat per wr_valid cycle and
// stall when wr_valid is low. A new command is accepted on the last beat of a
// burst so consecutive bursts run without a bubble.
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : burst_sequencer_if.slave (command, write beat, read beat, array)
// Optional: define BURST_CHOP_EN to add cmd_bc (half-length burst chop).
// ---------------------------------------------------------------------------
module burst_sequencer
   import mem_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2048,
   parameter int BL    = 8
) (
   input  logic clk,
   input  logic reset_n,
   burst_sequencer_if.slave bus
);

   localparam int AW = addr_width(DEPTH);
   localparam int OW = idx_width(BL);

   localparam logic [OW-1:0] LAST_FULL = OW'(BL - 1);
   localparam logic [OW-1:0] LAST_CHOP = OW'(BL / 2 - 1);

   seq_state_t       r_state;
   seq_state_t       w_state_next;
   logic [OW-1:0]    r_beat;
   logic             r_rd_valid;
   logic             r_rd_last;

   logic             w_chop;
   logic [OW-1:0]    w_last_beat;
   logic             w_issue;
   logic             w_last;
   logic             w_cmd_ready;
   logic             w_accept;
   logic             w_wr_ready;
   logic             w_arr_we;
   logic [AW-1:0]    w_arr_addr;
   logic [WIDTH-1:0] w_rd_data;

`ifdef BURST_CHOP_EN
   logic r_chop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_chop <= 1'b0;
      end else if (w_accept) begin
         r_chop <= bus.cmd_bc;
      end
   end

   assign w_chop = r_chop;
`else
   assign w_chop = 1'b0;
`endif

   assign w_last_beat = w_chop ? LAST_CHOP : LAST_FULL;
   assign w_accept    = bus.cmd_valid && w_cmd_ready;

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state: an accept (from IDLE or on a last beat) always starts
   // the new burst; otherwise a finished burst falls back to IDLE.
   always_comb begin
      w_state_next = r_state;
      if (w_accept) begin
         w_state_next = bus.cmd_wr ? WRITE : READ;
      end else if (w_last) begin
         w_state_next = IDLE;
      end
   end

   // FSM outputs
   always_comb begin
      w_issue    = 1'b0;
      w_wr_ready = 1'b0;
      w_arr_we   = 1'b0;
      case (r_state)
         WRITE: begin
            w_wr_ready = 1'b1;
            w_arr_we   = bus.wr_valid;
            w_issue    = bus.wr_valid;
         end
         READ: begin
            w_issue = 1'b1;
         end
         default: begin
         end
      endcase
      w_last      = w_issue && (r_beat == w_last_beat);
      w_cmd_ready = (r_state == IDLE) || w_last;
   end

   // Beat counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_beat <= '0;
      end else if (w_accept) begin
         r_beat <= '0;
      end else if (w_issue) begin
         r_beat <= r_beat + OW'(1);
      end
   end

   // Read strobes trail the issued address by the array's read latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
      end else begin
         r_rd_valid <= (r_state == READ);
         r_rd_last  <= (r_state == READ) && w_last;
      end
   end

   burst_addr_gen #(
      .DEPTH (DEPTH),
      .BL    (BL)
   ) u_addr_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_load    (w_accept),
      .i_advance (w_issue),
      .i_chop    (w_chop),
      .i_addr    (bus.cmd_addr),
      .o_addr    (w_arr_addr)
   );

   assign w_rd_data = bus.arr_o_data;

   assign bus.cmd_ready   = w_cmd_ready;
   assign bus.wr_ready    = w_wr_ready;
   assign bus.arr_addr    = w_arr_addr;
   assign bus.arr_rd_o_wr = w_arr_we;
   assign bus.arr_i_data  = bus.wr_data;
   assign bus.rd_data     = w_rd_data;
   assign bus.rd_valid    = r_rd_valid;
   assign bus.rd_last     = r_rd_last;

endmodule

// File: tb/tb_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_burst_sequencer
// Directed bench for burst_sequencer (WIDTH=8, DEPTH=2048, BL=8) with a
// behavioural registered-read array and a per-word write counter.
// Define BURST_CHOP_EN to also exercise the burst-chop read.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_burst_sequencer;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   burst_sequencer_if #(.WIDTH(8), .DEPTH(2048)) bus_if ();

   burst_sequencer #(
      .WIDTH (8),
      .DEPTH (2048),
      .BL    (8)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   // Array model: write and registered read on the same edge (read-first).
   logic [7:0] mem  [2048];
   int         wcnt [2048];
   bit         init_done = 1'b0;

   always @(posedge clk) begin
      if (!init_done) begin
         for (int j = 0; j < 2048; j++) begin
            mem[j]  <= 8'h00;
            wcnt[j] <= 0;
         end
         init_done <= 1'b1;
      end else if (bus_if.arr_rd_o_wr) begin
         mem[bus_if.arr_addr]  <= bus_if.arr_i_data;
         wcnt[bus_if.arr_addr] <= wcnt[bus_if.arr_addr] + 1;
      end
      bus_if.arr_o_data <= mem[bus_if.arr_addr];
   end

   int n_checks = 0;
   int n_errors = 0;

   logic [10:0] exp_a [8];
   logic [7:0]  exp_d [8];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Write burst of 8 beats with data d0, d0+1, ...; optional stall of
   // stall_n cycles before beat stall_at; optionally holds a read command to
   // rd_addr valid throughout so it is accepted on the last write beat.
   task automatic wr_burst(input logic [10:0] addr, input logic [7:0] d0,
                           input int stall_at, input int stall_n,
                           input bit hold_rd, input logic [10:0] rd_addr);
      logic [10:0] ea;
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_wr    = 1'b1;
      bus_if.cmd_addr  = addr;
      @(negedge clk);
      check_eq("wr_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
      tick();
      if (hold_rd) begin
         bus_if.cmd_wr   = 1'b0;
         bus_if.cmd_addr = rd_addr;
      end else begin
         bus_if.cmd_valid = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         ea = {addr[10:3], 3'(addr[2:0] + 3'(i))};
         if (i == stall_at) begin
            for (int s = 0; s < stall_n; s++) begin
               bus_if.wr_valid = 1'b0;
               bus_if.wr_data  = 8'hEE;
               @(negedge clk);
               check_eq("stall_we", 32'(bus_if.arr_rd_o_wr), 32'd0);
               check_eq("stall_addr", 32'(bus_if.arr_addr), 32'(ea));
               tick();
            end
         end
         bus_if.wr_valid = 1'b1;
         bus_if.wr_data  = d0 + 8'(i);
         @(negedge clk);
         check_eq("wr_addr", 32'(bus_if.arr_addr), 32'(ea));
         check_eq("wr_we", 32'(bus_if.arr_rd_o_wr), 32'd1);
         check_eq("wr_ready", 32'(bus_if.wr_ready), 32'd1);
         check_eq("wr_idata", 32'(bus_if.arr_i_data), 32'(d0 + 8'(i)));
         if (hold_rd)
            check_eq("b2b_cmd_ready", 32'(bus_if.cmd_ready), (i == 7) ? 32'd1 : 32'd0);
         tick();
      end
      bus_if.wr_valid = 1'b0;
      $display("write burst addr=%03h data0=%02h stall=%0d hold_rd=%0d", addr, d0, stall_n, hold_rd);
   endtask

   // Read burst of n beats checked against exp_a/exp_d. If pre is set the
   // command was already accepted and the first address issues this cycle.
   task automatic rd_burst(input logic [10:0] addr, input int n, input bit bc, input bit pre);
      if (!pre) begin
         bus_if.cmd_valid = 1'b1;
         bus_if.cmd_wr    = 1'b0;
         bus_if.cmd_addr  = addr;
`ifdef BURST_CHOP_EN
         bus_if.cmd_bc    = bc;
`endif
         @(negedge clk);
         check_eq("rd_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
         tick();
      end
      bus_if.cmd_valid = 1'b0;
`ifdef BURST_CHOP_EN
      bus_if.cmd_bc    = 1'b0;
`endif
      for (int k = 0; k <= n; k++) begin
         @(negedge clk);
         if (k < n) begin
            check_eq("rd_addr", 32'(bus_if.arr_addr), 32'(exp_a[k]));
            check_eq("rd_we", 32'(bus_if.arr_rd_o_wr), 32'd0);
            check_eq("rd_wr_ready", 32'(bus_if.wr_ready), 32'd0);
            check_eq("rd_cmd_ready", 32'(bus_if.cmd_ready), (k == n - 1) ? 32'd1 : 32'd0);
         end
         check_eq("rd_valid", 32'(bus_if.rd_valid), (k > 0) ? 32'd1 : 32'd0);
         if (k > 0) begin
            check_eq("rd_data", 32'(bus_if.rd_data), 32'(exp_d[k-1]));
            check_eq("rd_last", 32'(bus_if.rd_last), (k == n) ? 32'd1 : 32'd0);
         end
         tick();
      end
      @(negedge clk);
      check_eq("rd_idle_valid", 32'(bus_if.rd_valid), 32'd0);
      tick();
      $display("read burst addr=%03h beats=%0d bc=%0d", addr, n, bc);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_cmd_ready"}, 32'(bus_if.cmd_ready), 32'd1);
      check_eq({tag, "_wr_ready"}, 32'(bus_if.wr_ready), 32'd0);
      check_eq({tag, "_rd_valid"}, 32'(bus_if.rd_valid), 32'd0);
      check_eq({tag, "_rd_last"}, 32'(bus_if.rd_last), 32'd0);
      check_eq({tag, "_arr_addr"}, 32'(bus_if.arr_addr), 32'd0);
      check_eq({tag, "_we"}, 32'(bus_if.arr_rd_o_wr), 32'd0);
   endtask

   initial begin
      reset_n          = 1'b0;
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_wr    = 1'b0;
      bus_if.cmd_addr  = '0;
`ifdef BURST_CHOP_EN
      bus_if.cmd_bc    = 1'b0;
`endif
      bus_if.wr_data   = '0;
      bus_if.wr_valid  = 1'b0;

      tick();
      tick();
      @(negedge clk);
      check_reset_outputs("reset");
      tick();
      reset_n = 1'b1;
      $display("reset released");

      // Aligned write then read
      wr_burst(11'h010, 8'd1, -1, 0, 1'b0, 11'h000);
      exp_a = '{11'h010, 11'h011, 11'h012, 11'h013, 11'h014, 11'h015, 11'h016, 11'h017};
      exp_d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      rd_burst(11'h010, 8, 1'b0, 1'b0);

      // Wrapped read, critical word first
      exp_a = '{11'h015, 11'h016, 11'h017, 11'h010, 11'h011, 11'h012, 11'h013, 11'h014};
      exp_d = '{8'd6, 8'd7, 8'd8, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
      rd_burst(11'h015, 8, 1'b0, 1'b0);

      // Write with a 3-cycle stall before beat 4
      wr_burst(11'h020, 8'h21, 4, 3, 1'b0, 11'h000);
      for (int i = 0; i < 8; i++)
         check_eq("stall_wcnt", 32'(wcnt[32'h20 + i]), 32'd1);
      exp_a = '{11'h020, 11'h021, 11'h022, 11'h023, 11'h024, 11'h025, 11'h026, 11'h027};
      exp_d = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
      rd_burst(11'h020, 8, 1'b0, 1'b0);

      // Back-to-back: read accepted on the last write beat, zero bubble
      wr_burst(11'h040, 8'hA0, -1, 0, 1'b1, 11'h040);
      exp_a = '{11'h040, 11'h041, 11'h042, 11'h043, 11'h044, 11'h045, 11'h046, 11'h047};
      exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
      rd_burst(11'h040, 8, 1'b0, 1'b1);

      // Reset in the middle of a write burst to 0x30, after beat 3
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_wr    = 1'b1;
      bus_if.cmd_addr  = 11'h030;
      tick();
      bus_if.cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus_if.wr_valid = 1'b1;
         bus_if.wr_data  = 8'h31 + 8'(i);
         tick();
      end
      bus_if.wr_data = 8'h35;
      reset_n        = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check_reset_outputs("midrst");
         tick();
      end
      reset_n         = 1'b1;
      bus_if.wr_valid = 1'b0;
      @(negedge clk);
      check_eq("postrst_wr_ready", 32'(bus_if.wr_ready), 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         check_eq("rst_wcnt_done", 32'(wcnt[32'h30 + i]), 32'd1);
         check_eq("rst_wcnt_skip", 32'(wcnt[32'h34 + i]), 32'd0);
      end
      $display("reset mid-burst addr=030 after 4 beats");
      exp_a = '{11'h030, 11'h031, 11'h032, 11'h033, 11'h034, 11'h035, 11'h036, 11'h037};
      exp_d = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};
      rd_burst(11'h030, 8, 1'b0, 1'b0);

`ifdef BURST_CHOP_EN
      // Chopped read wraps inside the 4-word group 0x14..0x17
      exp_a = '{11'h016, 11'h017, 11'h014, 11'h015, 11'h000, 11'h000, 11'h000, 11'h000};
      exp_d = '{8'd7, 8'd8, 8'd5, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0};
      rd_burst(11'h016, 4, 1'b1, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
